serial_add_ctrl: RTL and testbench

Sequencing controller that performs an N-bit addition on a single bit-serial full-adder stage. It accepts two parallel operands and a carry-in through a valid/ready handshake. It shifts the operands LSB-first through the serial stage one bit per clock, assembles the parallel sum, and presents the result through a second valid/ready handshake. It is the parallel-bus front end the serial adder datapath needs before it can be used by a wider system.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_add_ctrl_if.sv | 28 ++
 rtl/serial_fa_bit.sv | 28 ++
 rtl/serial_add_ctrl.sv | 93 +++++++++
 tb/tb_serial_add_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM encoding and default operand width for the serial adder controller
package serial_add_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SHIFT = ST_SHIFT;
    localparam logic [1:0] DONE  = ST_DONE;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand/result handshake bundle between a producer/consumer and the controller
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, cin, out_ready,
        input  in_ready, out_valid, result, cout, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, cin, out_ready,
        output in_ready, out_valid, result, cout, busy
    );

endinterface

// File: rtl/serial_fa_bit.sv
// serial_fa_bit: single full-adder stage with a registered carry for bit-serial addition
module serial_fa_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic load_val,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    logic carry;

    assign s  = a ^ b ^ carry;
    assign co = (a & b) | (a & carry) | (b & carry);

    // carry is seeded with the carry-in on acceptance and advances once per shifted bit
    always_ff @(posedge clk) begin
        if (!rst_n)
            carry <= 1'b0;
        else if (load)
            carry <= load_val;
        else if (en)
            carry <= co;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: parallel valid/ready front end sequencing an N-bit add through one serial full adder
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] count;
    logic             cout_q;
    logic             s;
    logic             co;
    logic             accept;
    logic             shifting;
    logic             last;
    logic             release_out;
    logic [WIDTH-1:0] sum_next;

    assign accept      = (state == IDLE) && bus.in_valid;
    assign shifting    = (state == SHIFT);
    assign last        = shifting && (count == CNT_W'(WIDTH - 1));
    assign release_out = (state == DONE) && bus.out_ready;
    assign sum_next    = {s, sum[WIDTH-1:1]};

    serial_fa_bit u_fa (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (bus.cin),
        .en       (shifting),
        .a        (sh_a[0]),
        .b        (sh_b[0]),
        .s        (s),
        .co       (co)
    );

    // control: IDLE accepts, SHIFT runs WIDTH bit steps, DONE waits for the consumer
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= accept      ? SHIFT :
                     last        ? DONE  :
                     release_out ? IDLE  : state;
    end

    // operand shifters, partial-sum assembly and bit counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            sum   <= '0;
            count <= '0;
        end else if (accept) begin
            sh_a  <= bus.op_a;
            sh_b  <= bus.op_b;
            sum   <= '0;
            count <= '0;
        end else if (shifting) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            sum   <= sum_next;
            count <= count + 1'b1;
        end
    end

    // result capture on the final shift; held untouched until the next operation completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (last) begin
            result_q <= sum_next;
            cout_q   <= co;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed table plus corner-case sequences for the serial adder controller
module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] r;
        logic       co;
        int         hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_result"}, 32'(bus.result), 0);
        check({tag, "_cout"}, 32'(bus.cout), 0);
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] er, input logic eco, input int hold);
        int lat;
        bus.op_a = a;
        bus.op_b = b;
        bus.cin = c;
        bus.in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        bus.op_a = ~a;
        bus.op_b = ~b;
        bus.cin = ~c;
        check({tag, "_busy"}, 32'(bus.busy), 1);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), W);
        check({tag, "_result"}, 32'(bus.result), 32'(er));
        check({tag, "_cout"}, 32'(bus.cout), 32'(eco));
        for (int k = 0; k < hold; k++) begin
            step();
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
            check({tag, "_hold_result"}, 32'(bus.result), 32'(er));
            check({tag, "_hold_cout"}, 32'(bus.cout), 32'(eco));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_back_ready"}, 32'(bus.in_ready), 1);
    endtask

    vec_t tbl[8];
    vec_t b2b[4];

    initial begin
        tbl[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 5};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0};
        tbl[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 0};
        tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0};
        tbl[7] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 2};
        b2b[0] = '{8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 0};
        b2b[1] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b0, 0};
        b2b[2] = '{8'h99, 8'h88, 1'b1, 8'h00, 1'b0, 0};
        b2b[3] = '{8'h01, 8'hFE, 1'b0, 8'h00, 1'b0, 0};

        bus.in_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++)
            do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].r, tbl[i].co, tbl[i].hold);

        // new operands offered during SHIFT must be ignored
        begin
            int lat;
            bus.op_a = 8'h10;
            bus.op_b = 8'h20;
            bus.cin = 1'b0;
            bus.in_valid = 1'b1;
            step();
            bus.op_a = 8'hEE;
            bus.op_b = 8'h11;
            bus.cin = 1'b1;
            lat = 0;
            while (bus.out_valid !== 1'b1 && lat < 40) begin
                check("ignore_in_ready", 32'(bus.in_ready), 0);
                step();
                lat++;
            end
            bus.in_valid = 1'b0;
            check("ignore_latency", 32'(lat), W);
            check("ignore_result", 32'(bus.result), 32'h30);
            check("ignore_cout", 32'(bus.cout), 0);
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            check("ignore_drop_valid", 32'(bus.out_valid), 0);
        end

        // reset in the middle of SHIFT aborts with no result pulse
        begin
            int seen;
            bus.op_a = 8'hAB;
            bus.op_b = 8'h11;
            bus.cin = 1'b0;
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            for (int k = 0; k < 4; k++) step();
            rst_n = 1'b0;
            step();
            check_reset_outputs("midrst");
            rst_n = 1'b1;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                step();
                if (bus.out_valid === 1'b1) seen++;
            end
            check("midrst_no_valid", 32'(seen), 0);
            do_op("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);
        end

        // back-to-back with in_valid and out_ready held high
        begin
            int acc[4];
            int cyc;
            int n_in;
            int n_res;
            bit accepted;
            logic [8:0] ref_sum;
            n_in = 0;
            n_res = 0;
            cyc = 0;
            bus.out_ready = 1'b1;
            bus.op_a = b2b[0].a;
            bus.op_b = b2b[0].b;
            bus.cin = b2b[0].c;
            bus.in_valid = 1'b1;
            while (n_res < 4 && cyc < 200) begin
                if (bus.out_valid === 1'b1) begin
                    ref_sum = {1'b0, b2b[n_res].a} + {1'b0, b2b[n_res].b} + 9'(b2b[n_res].c);
                    check($sformatf("b2b%0d_result", n_res), 32'(bus.result), 32'(ref_sum[7:0]));
                    check($sformatf("b2b%0d_cout", n_res), 32'(bus.cout), 32'(ref_sum[8]));
                    n_res++;
                end
                accepted = 1'b0;
                if (bus.in_ready === 1'b1 && n_in < 4) begin
                    acc[n_in] = cyc;
                    n_in++;
                    accepted = 1'b1;
                end
                step();
                cyc++;
                if (accepted) begin
                    if (n_in < 4) begin
                        bus.op_a = b2b[n_in].a;
                        bus.op_b = b2b[n_in].b;
                        bus.cin = b2b[n_in].c;
                    end else begin
                        bus.in_valid = 1'b0;
                    end
                end
            end
            bus.out_ready = 1'b0;
            bus.in_valid = 1'b0;
            check("b2b_results_seen", 32'(n_res), 4);
            check("b2b_accepts_seen", 32'(n_in), 4);
            for (int k = 1; k < 4 && k < n_in; k++)
                check($sformatf("b2b_spacing%0d", k), 32'(acc[k] - acc[k-1]), W + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
